// File: rtl/bus_cycle_ctl_pkg.sv
// rtl/bus_cycle_ctl_pkg.sv - shared phi timing constants and steal FSM encoding
package bus_cycle_ctl_pkg;

  typedef logic [4:0] tick_t;
  typedef logic [3:0] half_t;
  typedef logic [2:0] lead_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_STEAL = 2'd2
  } steal_state_t;

  localparam int        TICKS_PER_PHI  = 32;
  localparam tick_t     TICK_LAST      = tick_t'(TICKS_PER_PHI - 1);
  localparam tick_t     PHI2_START     = 5'd16;
  localparam half_t     RAS_FALL       = 4'd5;
  localparam half_t     CAS_FALL       = 4'd7;
  localparam half_t     STROBE_RISE    = 4'd15;
  localparam lead_cnt_t BA_LEAD        = 3'd3;
  localparam tick_t     DB_DRIVE_START = 5'd2;

endpackage

// File: rtl/bus_cycle_ctl_dram_strobe_gen.sv
// rtl/bus_cycle_ctl_dram_strobe_gen.sv - half-cycle tick to ras/cas/row-column select decode
module bus_cycle_ctl_dram_strobe_gen
  import bus_cycle_ctl_pkg::*;
(
  input  logic [3:0] half_tick,
  output logic       ras,
  output logic       cas,
  output logic       addr_col
);

  // Same decode serves phi1 and phi2, so refresh and CPU/VIC accesses see identical timing.
  assign ras      = !((half_tick >= RAS_FALL) && (half_tick < STROBE_RISE));
  assign cas      = !((half_tick >= CAS_FALL) && (half_tick < STROBE_RISE));
  assign addr_col = (half_tick > RAS_FALL) && (half_tick <= STROBE_RISE);

endmodule

// File: rtl/bus_cycle_ctl.sv
// rtl/bus_cycle_ctl.sv - phi sequencing, VIC/CPU bus arbitration and DRAM strobe timing
module bus_cycle_ctl
  import bus_cycle_ctl_pkg::*;
(
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic       steal_req,
  input  logic       ce,
  input  logic       rw,
  output logic       clk_phi,
  output logic [4:0] phi_tick,
  output logic       ba,
  output logic       aec,
  output logic       ras,
  output logic       cas,
  output logic       addr_col,
  output logic       vic_write_ab,
  output logic       vic_write_db,
  output logic       ls245_dir,
  output logic       reg_wr_stb
);

  tick_t        tick, tick_nx;
  logic         running;
  steal_state_t state, state_nx;
  lead_cnt_t    lead_cnt, lead_cnt_nx;
  logic         ras_nx, cas_nx, addr_col_nx;
  logic         phi_nx, aec_nx, cpu_acc_nx, db_nx, wr_stb_nx;

  // Outputs are registered, so everything is decoded from the tick about to be entered.
  // The first clock after reset re-enters tick 0 so cycle 0 gets its steal_req sample.
  always_comb begin
    tick_nx = '0;
    if (running && tick != TICK_LAST) begin
      tick_nx = tick + 5'd1;
    end
  end

  always_comb begin
    state_nx    = state;
    lead_cnt_nx = lead_cnt;
    if (tick_nx == '0) begin
      case (state)
        ST_IDLE: begin
          if (steal_req) begin
            state_nx    = ST_LEAD;
            lead_cnt_nx = 3'd1;
          end
        end
        ST_LEAD: begin
          if (!steal_req) begin
            state_nx = ST_IDLE;
          end else if (lead_cnt == BA_LEAD) begin
            state_nx = ST_STEAL;
          end else begin
            lead_cnt_nx = lead_cnt + 3'd1;
          end
        end
        ST_STEAL: begin
          if (!steal_req) begin
            state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  bus_cycle_ctl_dram_strobe_gen u_strobe (
    .half_tick (tick_nx[3:0]),
    .ras       (ras_nx),
    .cas       (cas_nx),
    .addr_col  (addr_col_nx)
  );

  // LEAD leaves aec alone, so a CPU access in a cycle that starts a steal still completes.
  always_comb begin
    phi_nx     = (tick_nx >= PHI2_START);
    aec_nx     = (state_nx == ST_STEAL) ? 1'b0 : phi_nx;
    cpu_acc_nx = aec_nx && phi_nx && !ce;
    db_nx      = cpu_acc_nx && rw && (tick_nx >= (PHI2_START + DB_DRIVE_START));
    wr_stb_nx  = cpu_acc_nx && !rw && (tick_nx == TICK_LAST);
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      running      <= 1'b0;
      tick         <= '0;
      state        <= ST_IDLE;
      lead_cnt     <= '0;
      clk_phi      <= 1'b0;
      ba           <= 1'b1;
      aec          <= 1'b0;
      ras          <= 1'b1;
      cas          <= 1'b1;
      addr_col     <= 1'b0;
      vic_write_ab <= 1'b0;
      vic_write_db <= 1'b0;
      ls245_dir    <= 1'b0;
      reg_wr_stb   <= 1'b0;
    end else begin
      running      <= 1'b1;
      tick         <= tick_nx;
      state        <= state_nx;
      lead_cnt     <= lead_cnt_nx;
      clk_phi      <= phi_nx;
      ba           <= (state_nx == ST_IDLE);
      aec          <= aec_nx;
      ras          <= ras_nx;
      cas          <= cas_nx;
      addr_col     <= addr_col_nx;
      vic_write_ab <= !aec_nx;
      vic_write_db <= db_nx;
      ls245_dir    <= db_nx;
      reg_wr_stb   <= wr_stb_nx;
    end
  end

  assign phi_tick = tick;

endmodule
